// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator and pixel-output stage.
//
// A free-running h/v raster counter issues pixel requests (REQ, CURX, CURY, LINE_START,
// FRAME_START) one enabled edge after the counter position. The client answers on
// COLOR_DATA_IN, which is sampled on the PIPE-th enabled edge after the request. The
// matching sync/blank decode rides a PIPE-deep shift register, so RED/GREEN/BLUE, HS, VS
// and the blanking flags leave the block aligned with the colour they belong to.
//
// Ports:
//   CLK_PIXEL      pixel clock
//   RST            asynchronous active-high reset
//   EN             pixel enable; every register advances only on edges with EN=1
//   CURX, CURY     requested pixel coordinate, 0 when REQ=0
//   REQ            CURX/CURY is a visible pixel
//   LINE_START     strobe together with the request for x=0
//   FRAME_START    strobe together with the request for (0,0)
//   COLOR_DATA_IN  {R,G,B} for the coordinate requested PIPE enabled edges earlier
//   RED/GREEN/BLUE registered colour, 0 while BLANK
//   HS, VS         registered syncs, driven to HS_POL/VS_POL while active
//   HBLANK, VBLANK, BLANK  registered blanking flags aligned with the colour
//   FRAME_CNT      count of completed frames, wraps 0xFFFF -> 0
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned R_W      = 3,
  parameter int unsigned G_W      = 3,
  parameter int unsigned B_W      = 2,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned PIPE     = 2
) (
  input  logic                     CLK_PIXEL,
  input  logic                     RST,
  input  logic                     EN,
  output logic [X_W-1:0]           CURX,
  output logic [Y_W-1:0]           CURY,
  output logic                     REQ,
  output logic                     LINE_START,
  output logic                     FRAME_START,
  input  logic [R_W+G_W+B_W-1:0]   COLOR_DATA_IN,
  output logic [R_W-1:0]           RED,
  output logic [G_W-1:0]           GREEN,
  output logic [B_W-1:0]           BLUE,
  output logic                     HS,
  output logic                     VS,
  output logic                     HBLANK,
  output logic                     VBLANK,
  output logic                     BLANK,
  output logic [15:0]              FRAME_CNT
);

  localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W   = $clog2(H_TOT);
  localparam int unsigned VC_W   = $clog2(V_TOT);
  localparam int unsigned C_W    = R_W + G_W + B_W;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  if (PIPE < 1 || PIPE > 8) begin : g_pipe_chk
    $error("vga_timing_gen: PIPE must be in 1..8");
  end
  if (X_W < $clog2(H_ACTIVE)) begin : g_xw_chk
    $error("vga_timing_gen: X_W too narrow for H_ACTIVE");
  end
  if (Y_W < $clog2(V_ACTIVE)) begin : g_yw_chk
    $error("vga_timing_gen: Y_W too narrow for V_ACTIVE");
  end

  logic [HC_W-1:0] h_q;
  logic [VC_W-1:0] v_q;
  logic [31:0]     h_cur, v_cur;
  logic            h_last, v_last;
  logic            vis, hs_dec, vs_dec, hb_dec, vb_dec;

  // Stage-0 decode straight from the raster position.
  always_comb begin
    h_cur  = 32'(h_q);
    v_cur  = 32'(v_q);
    h_last = (h_cur == H_TOT - 1);
    v_last = (v_cur == V_TOT - 1);
    hb_dec = !(h_cur < H_ACTIVE);
    vb_dec = !(v_cur < V_ACTIVE);
    vis    = !hb_dec && !vb_dec;
    hs_dec = (h_cur >= HS_BEG) && (h_cur < HS_END);
    vs_dec = (v_cur >= VS_BEG) && (v_cur < VS_END);
  end

  // Raster counters and completed-frame count.
  always_ff @(posedge CLK_PIXEL or posedge RST) begin
    if (RST) begin
      h_q       <= '0;
      v_q       <= '0;
      FRAME_CNT <= '0;
    end else if (EN) begin
      if (h_last) begin
        h_q <= '0;
        if (v_last) begin
          v_q       <= '0;
          FRAME_CNT <= FRAME_CNT + 16'd1;
        end else begin
          v_q <= v_q + VC_W'(1);
        end
      end else begin
        h_q <= h_q + HC_W'(1);
      end
    end
  end

  // Request stage: registered on the same edge as the first pipeline slot.
  always_ff @(posedge CLK_PIXEL or posedge RST) begin
    if (RST) begin
      REQ         <= 1'b0;
      CURX        <= '0;
      CURY        <= '0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else if (EN) begin
      REQ         <= vis;
      CURX        <= vis ? X_W'(h_q) : '0;
      CURY        <= vis ? Y_W'(v_q) : '0;
      LINE_START  <= vis && (h_cur == 0);
      FRAME_START <= vis && (h_cur == 0) && (v_cur == 0);
    end
  end

  // Sync/blank decode delayed to meet the client's colour. Slot 0 loads on the request
  // edge, so the output register below lands exactly PIPE enabled edges after REQ.
  logic [PIPE-1:0] hs_pipe, vs_pipe, hb_pipe, vb_pipe;

  always_ff @(posedge CLK_PIXEL or posedge RST) begin
    if (RST) begin
      hs_pipe <= '0;
      vs_pipe <= '0;
      hb_pipe <= '1;
      vb_pipe <= '1;
    end else if (EN) begin
      hs_pipe[0] <= hs_dec;
      vs_pipe[0] <= vs_dec;
      hb_pipe[0] <= hb_dec;
      vb_pipe[0] <= vb_dec;
      for (int i = 1; i < PIPE; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        hb_pipe[i] <= hb_pipe[i-1];
        vb_pipe[i] <= vb_pipe[i-1];
      end
    end
  end

  logic out_blank;
  assign out_blank = hb_pipe[PIPE-1] | vb_pipe[PIPE-1];

  // Pixel output register: colour sampled here, forced to black while blanking.
  always_ff @(posedge CLK_PIXEL or posedge RST) begin
    if (RST) begin
      RED    <= '0;
      GREEN  <= '0;
      BLUE   <= '0;
      HS     <= ~HS_POL;
      VS     <= ~VS_POL;
      HBLANK <= 1'b1;
      VBLANK <= 1'b1;
      BLANK  <= 1'b1;
    end else if (EN) begin
      HS     <= hs_pipe[PIPE-1] ? HS_POL : ~HS_POL;
      VS     <= vs_pipe[PIPE-1] ? VS_POL : ~VS_POL;
      HBLANK <= hb_pipe[PIPE-1];
      VBLANK <= vb_pipe[PIPE-1];
      BLANK  <= out_blank;
      if (out_blank) begin
        RED   <= '0;
        GREEN <= '0;
        BLUE  <= '0;
      end else begin
        RED   <= COLOR_DATA_IN[C_W-1 -: R_W];
        GREEN <= COLOR_DATA_IN[G_W+B_W-1 -: G_W];
        BLUE  <= COLOR_DATA_IN[B_W-1:0];
      end
    end
  end

endmodule
